// File: rtl/seq_pkg.sv
// Shared types for the multicycle sequencer: state encoding and memory-port select values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

    // State encoding is visible on state_o, so the order here is the debug encoding.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6
    } state_e;

    // Shared memory port address mux select.
    localparam logic MEM_SEL_FETCH = 1'b0;
    localparam logic MEM_SEL_DATA  = 1'b1;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request waits without an ack and flags expiry at the limit.
// Latency: expired_o is combinational from the count and en_i (same cycle).
// Backpressure: none; an ack (en_i low) in the limit cycle suppresses expiry.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over count; the counter never needs to pass LIMIT because expiry halts the sequencer.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The current un-acked cycle is the MEM_TIMEOUT-th one.
    assign expired_o = en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB and owns the shared memory port.
// Latency: 3 (branch), 4 (ALU/jump/store), 5 (load) cycles with 0-wait memory; +1 per wait cycle.
// Backpressure: memory stalls via mem_ack_i; an un-acked request times out into HALT.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned CWIDTH      = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              run_i,
    input  logic              regwren_i,
    input  logic              memren_i,
    input  logic              memwren_i,
    input  logic              pcsel_i,
    input  logic              branch_i,
    input  logic              br_taken_i,
    input  logic              illegal_i,
    input  logic              mem_ack_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic              mem_sel_o,
    output logic              ir_we_o,
    output logic              pc_we_o,
    output logic              pc_next_sel_o,
    output logic              rf_we_o,
    output logic [2:0]        state_o,
    output logic              halted_o,
    output logic              err_timeout_o,
    output logic [CWIDTH-1:0] retired_o
);

    // Reject degenerate builds at elaboration.
    if (DWIDTH < 1 || CWIDTH < 1 || MEM_TIMEOUT < 1) begin : g_param_check
        $error("multicycle_sequencer: DWIDTH, CWIDTH and MEM_TIMEOUT must all be >= 1");
    end

    state_e            state_q, state_d;
    logic              err_q, err_d;
    logic [CWIDTH-1:0] ret_q, ret_d;
    logic              commit;
    logic              mem_wait;
    logic              timer_en;
    logic              timer_clr;
    logic              timer_expired;

    // The timer only runs while a request is outstanding; leaving FETCH/MEM (or an ack) zeroes it,
    // so it is always zero on entry to the next request state.
    assign mem_wait  = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign timer_en  = mem_wait && !mem_ack_i;
    assign timer_clr = !mem_wait || mem_ack_i;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    // Next-state, strobes and commit; commit is the last cycle of every instruction.
    always_comb begin
        state_d       = state_q;
        err_d         = err_q;
        ret_d         = ret_q;
        commit        = 1'b0;
        mem_req_o     = 1'b0;
        mem_we_o      = 1'b0;
        mem_sel_o     = MEM_SEL_FETCH;
        ir_we_o       = 1'b0;
        pc_we_o       = 1'b0;
        pc_next_sel_o = 1'b0;
        rf_we_o       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req_o = 1'b1;
                mem_sel_o = MEM_SEL_FETCH;
                if (mem_ack_i) begin
                    ir_we_o = 1'b1;
                    state_d = ST_DECODE;
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_DECODE: begin
                // A simultaneous load and store is not a real instruction.
                if (illegal_i || (memren_i && memwren_i)) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (memren_i || memwren_i) begin
                    state_d = ST_MEM;
                end else if (regwren_i) begin
                    state_d = ST_WB;
                end else begin
                    commit = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req_o = 1'b1;
                mem_sel_o = MEM_SEL_DATA;
                mem_we_o  = memwren_i;
                if (mem_ack_i) begin
                    if (memren_i) begin
                        state_d = ST_WB;
                    end else begin
                        commit = 1'b1;
                    end
                end else if (timer_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_HALT;
                end
            end
            ST_WB: begin
                rf_we_o = 1'b1;
                commit  = 1'b1;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase

        if (commit) begin
            pc_we_o       = 1'b1;
            pc_next_sel_o = pcsel_i || (branch_i && br_taken_i);
            ret_d         = ret_q + {{(CWIDTH-1){1'b0}}, 1'b1};
            state_d       = run_i ? ST_FETCH : ST_IDLE;
        end
    end

    // State, sticky timeout flag and retired-instruction counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            ret_q   <= ret_d;
        end
    end

    assign state_o       = state_q;
    assign halted_o      = (state_q == ST_HALT);
    assign err_timeout_o = err_q;
    assign retired_o     = ret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: per-cycle vector table plus hand-written corner sequences.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Built with CWIDTH=4 so the retired counter wrap is reachable.
module tb_multicycle_sequencer;

    logic       clk;
    logic       reset_n;
    logic       run_i, regwren_i, memren_i, memwren_i, pcsel_i;
    logic       branch_i, br_taken_i, illegal_i, mem_ack_i;
    logic       mem_req_o, mem_we_o, mem_sel_o, ir_we_o, pc_we_o;
    logic       pc_next_sel_o, rf_we_o, halted_o, err_timeout_o;
    logic [2:0] state_o;
    logic [3:0] retired_o;

    int checks = 0;
    int errors = 0;

    multicycle_sequencer #(
        .DWIDTH      (32),
        .CWIDTH      (4),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .run_i         (run_i),
        .regwren_i     (regwren_i),
        .memren_i      (memren_i),
        .memwren_i     (memwren_i),
        .pcsel_i       (pcsel_i),
        .branch_i      (branch_i),
        .br_taken_i    (br_taken_i),
        .illegal_i     (illegal_i),
        .mem_ack_i     (mem_ack_i),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_sel_o     (mem_sel_o),
        .ir_we_o       (ir_we_o),
        .pc_we_o       (pc_we_o),
        .pc_next_sel_o (pc_next_sel_o),
        .rf_we_o       (rf_we_o),
        .state_o       (state_o),
        .halted_o      (halted_o),
        .err_timeout_o (err_timeout_o),
        .retired_o     (retired_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input vector bit order: {run, regwren, memren, memwren, pcsel, branch, br_taken, illegal, ack}
    // Output vector bit order: {mem_req, mem_we, mem_sel, ir_we, pc_we, pc_sel, rf_we, halted, err}
    typedef struct {
        logic [8:0] in;
        logic [2:0] st;
        logic [8:0] o;
        logic [3:0] ret;
    } vec_t;

    localparam logic [8:0] O_NONE   = 9'b0_0_0_0_0_0_0_0_0;
    localparam logic [8:0] O_FREQ   = 9'b1_0_0_0_0_0_0_0_0;
    localparam logic [8:0] O_FACK   = 9'b1_0_0_1_0_0_0_0_0;
    localparam logic [8:0] O_MRD    = 9'b1_0_1_0_0_0_0_0_0;
    localparam logic [8:0] O_WB0    = 9'b0_0_0_0_1_0_1_0_0;
    localparam logic [8:0] O_WB1    = 9'b0_0_0_0_1_1_1_0_0;
    localparam logic [8:0] O_BRT    = 9'b0_0_0_0_1_1_0_0_0;
    localparam logic [8:0] O_STC    = 9'b1_1_1_0_1_0_0_0_0;
    localparam logic [8:0] O_HALT   = 9'b0_0_0_0_0_0_0_1_0;

    localparam logic [8:0] I_ADD    = 9'b1_1_0_0_0_0_0_0_1;
    localparam logic [8:0] I_LD     = 9'b1_1_1_0_0_0_0_0_1;
    localparam logic [8:0] I_LD_NA  = 9'b1_1_1_0_0_0_0_0_0;
    localparam logic [8:0] I_BEQ    = 9'b1_0_0_0_0_1_1_0_1;
    localparam logic [8:0] I_ST     = 9'b1_0_0_1_0_0_0_0_1;
    localparam logic [8:0] I_ST_NA  = 9'b1_0_0_1_0_0_0_0_0;
    localparam logic [8:0] I_JAL    = 9'b1_1_0_0_1_0_0_0_1;
    localparam logic [8:0] I_JAL_RL = 9'b0_1_0_0_1_0_0_0_1;
    localparam logic [8:0] I_STOP   = 9'b0_0_0_0_0_0_0_0_1;
    localparam logic [8:0] I_RUN_NA = 9'b1_0_0_0_0_0_0_0_0;
    localparam logic [8:0] I_RUN_A  = 9'b1_0_0_0_0_0_0_0_1;
    localparam logic [8:0] I_ILL    = 9'b1_0_0_0_0_0_0_1_1;
    localparam logic [8:0] I_ALL    = 9'b1_1_1_1_1_1_1_1_1;
    localparam logic [8:0] I_BOTH   = 9'b1_0_1_1_0_0_0_0_1;

    function automatic vec_t mk(logic [8:0] in, logic [2:0] st, logic [8:0] o, logic [3:0] ret);
        vec_t v;
        v.in  = in;
        v.st  = st;
        v.o   = o;
        v.ret = ret;
        return v;
    endfunction

    task automatic set_in(input logic [8:0] v);
        {run_i, regwren_i, memren_i, memwren_i, pcsel_i, branch_i, br_taken_i, illegal_i, mem_ack_i} = v;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {mem_req_o, mem_we_o, mem_sel_o, ir_we_o, pc_we_o, pc_next_sel_o, rf_we_o, halted_o, err_timeout_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one rising edge, then release; returns at posedge+1 in IDLE.
    task automatic do_reset();
        reset_n = 1'b0;
        set_in(9'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // From IDLE: run, fetch with immediate ack, decode; returns in EXECUTE.
    task automatic to_execute(input logic [8:0] v);
        set_in(v);
        repeat (3) step();
    endtask

    vec_t tbl[32];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // ADD, then load with 3 wait cycles, taken BEQ, 0-wait store, JAL with run dropped, idle, illegal.
        tbl[0]  = mk(I_ADD,    3'd0, O_NONE, 4'd0);
        tbl[1]  = mk(I_ADD,    3'd1, O_FACK, 4'd0);
        tbl[2]  = mk(I_ADD,    3'd2, O_NONE, 4'd0);
        tbl[3]  = mk(I_ADD,    3'd3, O_NONE, 4'd0);
        tbl[4]  = mk(I_ADD,    3'd5, O_WB0,  4'd0);
        tbl[5]  = mk(I_LD,     3'd1, O_FACK, 4'd1);
        tbl[6]  = mk(I_LD,     3'd2, O_NONE, 4'd1);
        tbl[7]  = mk(I_LD,     3'd3, O_NONE, 4'd1);
        tbl[8]  = mk(I_LD_NA,  3'd4, O_MRD,  4'd1);
        tbl[9]  = mk(I_LD_NA,  3'd4, O_MRD,  4'd1);
        tbl[10] = mk(I_LD_NA,  3'd4, O_MRD,  4'd1);
        tbl[11] = mk(I_LD,     3'd4, O_MRD,  4'd1);
        tbl[12] = mk(I_LD,     3'd5, O_WB0,  4'd1);
        tbl[13] = mk(I_BEQ,    3'd1, O_FACK, 4'd2);
        tbl[14] = mk(I_BEQ,    3'd2, O_NONE, 4'd2);
        tbl[15] = mk(I_BEQ,    3'd3, O_BRT,  4'd2);
        tbl[16] = mk(I_ST,     3'd1, O_FACK, 4'd3);
        tbl[17] = mk(I_ST,     3'd2, O_NONE, 4'd3);
        tbl[18] = mk(I_ST,     3'd3, O_NONE, 4'd3);
        tbl[19] = mk(I_ST,     3'd4, O_STC,  4'd3);
        tbl[20] = mk(I_JAL,    3'd1, O_FACK, 4'd4);
        tbl[21] = mk(I_JAL,    3'd2, O_NONE, 4'd4);
        tbl[22] = mk(I_JAL_RL, 3'd3, O_NONE, 4'd4);
        tbl[23] = mk(I_JAL_RL, 3'd5, O_WB1,  4'd4);
        tbl[24] = mk(I_STOP,   3'd0, O_NONE, 4'd5);
        tbl[25] = mk(I_STOP,   3'd0, O_NONE, 4'd5);
        tbl[26] = mk(I_RUN_NA, 3'd0, O_NONE, 4'd5);
        tbl[27] = mk(I_RUN_NA, 3'd1, O_FREQ, 4'd5);
        tbl[28] = mk(I_RUN_A,  3'd1, O_FACK, 4'd5);
        tbl[29] = mk(I_ILL,    3'd2, O_NONE, 4'd5);
        tbl[30] = mk(I_ALL,    3'd6, O_HALT, 4'd5);
        tbl[31] = mk(I_ALL,    3'd6, O_HALT, 4'd5);

        // Asynchronous reset with live inputs: everything quiet before any clock edge.
        reset_n = 1'b0;
        set_in(I_ALL);
        #3;
        chk("reset_state",   32'(state_o),   32'd0);
        chk("reset_outputs", 32'(outs()),    32'(O_NONE));
        chk("reset_retired", 32'(retired_o), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            set_in(tbl[i].in);
            @(negedge clk);
            chk($sformatf("vec%0d_state", i),   32'(state_o),   32'(tbl[i].st));
            chk($sformatf("vec%0d_outputs", i), 32'(outs()),    32'(tbl[i].o));
            chk($sformatf("vec%0d_retired", i), 32'(retired_o), 32'(tbl[i].ret));
            step();
        end

        // Store never acked: exactly MEM_TIMEOUT cycles in MEM, then sticky timeout halt.
        do_reset();
        to_execute(I_ST);
        set_in(I_ST_NA);
        step();
        @(negedge clk);
        chk("to_mem_req_we_sel", 32'({mem_req_o, mem_we_o, mem_sel_o}), 32'b111);
        n = 0;
        while (state_o == 3'd4 && n < 40) begin
            n++;
            step();
        end
        chk("timeout_mem_cycles", 32'(n), 32'd16);
        @(negedge clk);
        chk("timeout_state",   32'(state_o), 32'd6);
        chk("timeout_outputs", 32'(outs()),  32'(9'b0_0_0_0_0_0_0_1_1));
        set_in(I_ALL);
        repeat (3) step();
        @(negedge clk);
        chk("halt_ignores_ack", 32'({state_o, halted_o, err_timeout_o, mem_req_o, ir_we_o}), 32'({3'd6, 4'b1100}));
        reset_n = 1'b0;
        #1;
        chk("reset_clears_halt", 32'({state_o, halted_o, err_timeout_o}), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Ack arriving in the limit cycle completes the load normally.
        to_execute(I_LD);
        set_in(I_LD_NA);
        step();
        repeat (15) step();
        set_in(I_LD);
        @(negedge clk);
        chk("limit_cycle_state", 32'(state_o), 32'd4);
        step();
        @(negedge clk);
        chk("limit_ack_wb", 32'({state_o, rf_we_o, halted_o, err_timeout_o}), 32'({3'd5, 3'b100}));
        step();
        chk("limit_ack_retired", 32'(retired_o), 32'd1);

        // Load and store decoded together halts without a timeout flag or a commit.
        do_reset();
        set_in(I_BOTH);
        repeat (2) step();
        @(negedge clk);
        chk("both_decode_state", 32'(state_o), 32'd2);
        step();
        @(negedge clk);
        chk("both_halt", 32'({state_o, halted_o, err_timeout_o, pc_we_o}), 32'({3'd6, 3'b100}));
        chk("both_retired", 32'(retired_o), 32'd0);

        // Reset asserted mid-MEM while the request is outstanding.
        do_reset();
        to_execute(I_ST);
        set_in(I_ST_NA);
        step();
        #2;
        chk("midmem_req", 32'({state_o, mem_req_o}), 32'({3'd4, 1'b1}));
        reset_n = 1'b0;
        #1;
        chk("midmem_reset_state",   32'(state_o), 32'd0);
        chk("midmem_reset_outputs", 32'(outs()),  32'(O_NONE));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Sixteen taken branches: 4-bit retired counter wraps 15 -> 0.
        set_in(I_BEQ);
        step();
        for (int k = 1; k <= 16; k++) begin
            repeat (3) step();
            if (k == 15) chk("wrap_retired_15", 32'(retired_o), 32'd15);
            if (k == 16) chk("wrap_retired_0",  32'({state_o, retired_o}), 32'({3'd1, 4'd0}));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
